// File: rtl/soc_bus_pkg.sv
// Shared bus definitions: owner tags, default video window and memory read latency.
package soc_bus_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_t;

    localparam logic [15:0] VRAM_BASE_DEFAULT  = 16'hFE00;
    localparam int          VRAM_BYTES_DEFAULT = 512;
    localparam int          MEM_READ_LATENCY   = 1;

endpackage

// File: rtl/byte_fifo2.sv
// Two-entry byte FIFO for video prefetch; flush wins over push and pop.
module byte_fifo2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    input  logic       flush,
    output logic [1:0] count,
    output logic [7:0] head
);

    logic [7:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop & (count != 2'd0);
    assign do_push = push & ((count != 2'd2) | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= 8'h00;
            mem[1] <= 8'h00;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the memory bus between the CPU and the video byte fetcher.
// Optional build macro VIDEO_URGENT_EN: an empty, idle video pipeline beats the CPU.
module mem_bus_arbiter
    import soc_bus_pkg::*;
#(
    parameter logic [15:0] VRAM_BASE  = VRAM_BASE_DEFAULT,
    parameter int          VRAM_BYTES = VRAM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpuAddr,
    input  logic [7:0]  cpuDataWrite,
    input  logic        cpuWrite,
    input  logic        cpuStrobe,
    output logic        cpuWait,
    output logic [7:0]  cpuDataRead,
    input  logic        vidStart,
    input  logic        vidPop,
    output logic [7:0]  vidByte,
    output logic        vidValid,
    output logic [15:0] memAddr,
    output logic [7:0]  memDataWrite,
    output logic        memWrite,
    output logic        memStrobe,
    input  logic [7:0]  memDataRead
);

    localparam int VA_W = (VRAM_BYTES > 1) ? $clog2(VRAM_BYTES) : 1;

    owner_t          own_p1;
    logic            wr_p1;
    logic [VA_W-1:0] vid_addr;
    logic [15:0]     addr_q;
    logic [7:0]      cpu_rd_q;
    logic            last_vid;

    logic [1:0]      fifo_count;
    logic [7:0]      fifo_head;
    logic            inflight;
    logic            cpu_req;
    logic            vid_req;
    logic            urgent;
    logic            cpu_grant;
    logic            vid_grant;
    logic            cpu_read_p1;

    assign inflight    = (own_p1 == OWN_VID);
    assign cpu_read_p1 = (own_p1 == OWN_CPU) & ~wr_p1;
    assign cpu_req     = reset & cpuStrobe;
    assign vid_req     = reset & ~vidStart &
                         (({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2);

`ifdef VIDEO_URGENT_EN
    assign urgent = (fifo_count == 2'd0) & ~inflight;
`else
    assign urgent = 1'b0;
`endif

    // Ties go to whoever did not win last; urgent video overrides that.
    assign cpu_grant = cpu_req & ~(vid_req & (urgent | ~last_vid));
    assign vid_grant = vid_req & ~cpu_grant;

    always_comb begin
        memAddr      = addr_q;
        memDataWrite = 8'h00;
        memWrite     = 1'b0;
        memStrobe    = 1'b0;
        if (cpu_grant) begin
            memAddr      = cpuAddr;
            memDataWrite = cpuDataWrite;
            memWrite     = cpuWrite;
            memStrobe    = 1'b1;
        end else if (vid_grant) begin
            memAddr   = VRAM_BASE + 16'(vid_addr);
            memStrobe = 1'b1;
        end
    end

    assign cpuWait     = cpuStrobe & ~cpu_grant;
    assign cpuDataRead = cpu_read_p1 ? memDataRead : cpu_rd_q;
    assign vidValid    = (fifo_count != 2'd0);
    assign vidByte     = fifo_head;

    // Grant stage -> data stage: owner tag selects where the returned byte goes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            own_p1   <= OWN_NONE;
            wr_p1    <= 1'b0;
            vid_addr <= '0;
            addr_q   <= 16'h0000;
            cpu_rd_q <= 8'h00;
            last_vid <= 1'b1;
        end else begin
            own_p1 <= cpu_grant ? OWN_CPU : (vid_grant ? OWN_VID : OWN_NONE);
            wr_p1  <= cpu_grant & cpuWrite;
            if (vidStart) begin
                vid_addr <= '0;
            end else if (vid_grant) begin
                vid_addr <= vid_addr + VA_W'(1);
            end
            if (cpu_grant | vid_grant) begin
                addr_q <= memAddr;
            end
            if (cpu_read_p1) begin
                cpu_rd_q <= memDataRead;
            end
            if (cpu_grant) begin
                last_vid <= 1'b0;
            end else if (vid_grant) begin
                last_vid <= 1'b1;
            end
        end
    end

    byte_fifo2 u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight & ~vidStart),
        .din   (memDataRead),
        .pop   (vidPop),
        .flush (vidStart),
        .count (fifo_count),
        .head  (fifo_head)
    );

endmodule
